// File: rtl/fork4_pkg.sv
// Shared definitions for the four-way broadcast fork controller.
// Holds the branch count, the controller state encoding and the default token width.
package fork4_pkg;

  localparam int NOUT      = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } stateE;

  // Branches still owed the token once this cycle's acceptances are applied.
  function automatic logic [NOUT-1:0] pendingAfter(input logic [NOUT-1:0] pending,
                                                   input logic [NOUT-1:0] ready);
    return pending & ~ready;
  endfunction

endpackage

// File: rtl/fork4_wdog.sv
// No-progress watchdog for fork4_ctrl: saturating counter, sticky stall flag and stuck-branch mask.
// Only instantiated when FORK4_WATCHDOG_EN is defined.
module fork4_wdog
  import fork4_pkg::*;
#(
  parameter int WDOG_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bcast,
  input  logic            capture,
  input  logic [NOUT-1:0] pending,
  input  logic [NOUT-1:0] outReady,
  output logic            stallErr,
  output logic [NOUT-1:0] stuckMask
);

  localparam int            CW    = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYC);

  logic [CW-1:0]   cntR;
  logic [CW-1:0]   cntNextS;
  logic            progressS;
  logic            hitS;
  logic            stallErrR;
  logic [NOUT-1:0] stuckMaskR;

  // Next count: any handshake or new capture restarts the no-progress window.
  always_comb begin
    cntNextS  = cntR;
    hitS      = 1'b0;
    progressS = bcast && ((pending & outReady) != {NOUT{1'b0}});
    if (capture || progressS) begin
      cntNextS = {CW{1'b0}};
    end else if (bcast && (cntR != LIMIT)) begin
      cntNextS = cntR + CW'(1);
      hitS     = (cntNextS == LIMIT);
    end else begin
      cntNextS = cntR;
    end
  end

  // Counter, sticky flag and first-stall snapshot of the pending branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntR       <= {CW{1'b0}};
      stallErrR  <= 1'b0;
      stuckMaskR <= {NOUT{1'b0}};
    end else begin
      cntR <= cntNextS;
      if (hitS && !stallErrR) begin
        stallErrR  <= 1'b1;
        stuckMaskR <= pending;
      end
    end
  end

  assign stallErr  = stallErrR;
  assign stuckMask = stuckMaskR;

endmodule

// File: rtl/fork4_ctrl.sv
// Broadcast fork: captures one upstream token and offers it to every enabled branch until each accepts.
// Optional watchdog compiled in with FORK4_WATCHDOG_EN; otherwise stall_err/stuck_mask are tied low.
module fork4_ctrl
  import fork4_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WDOG_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [NOUT-1:0]  branch_en,
  output logic [NOUT-1:0]  out_valid,
  input  logic [NOUT-1:0]  out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             stall_err,
  output logic [NOUT-1:0]  stuck_mask
);

  if (WDOG_CYC < 1) begin : gBadWdogCfg
    $error("fork4_ctrl: WDOG_CYC must be at least 1");
  end

  stateE           stateR;
  stateE           stateNextS;
  stateE           stateHoldS;
  logic [NOUT-1:0] pendingR;
  logic [NOUT-1:0] pendingNextS;
  logic [NOUT-1:0] pendingHoldS;
  logic [NOUT-1:0] remainS;
  logic [WIDTH-1:0] dataR;
  logic            readyRawS;
  logic            inReadyS;
  logic            captureS;
  logic            anyEnS;

  // Next state, pending set and upstream ready; a new token may land in the same
  // cycle the last pending branch completes, giving one token per cycle.
  always_comb begin
    stateHoldS   = stateR;
    pendingHoldS = pendingR;
    readyRawS    = 1'b0;
    inReadyS     = 1'b0;
    captureS     = 1'b0;
    anyEnS       = (branch_en != {NOUT{1'b0}});
    remainS      = pendingAfter(pendingR, out_ready);
    case (stateR)
      IDLE: begin
        readyRawS    = anyEnS;
        pendingHoldS = {NOUT{1'b0}};
        stateHoldS   = IDLE;
      end
      BCAST: begin
        readyRawS    = (remainS == {NOUT{1'b0}}) && anyEnS;
        pendingHoldS = remainS;
        stateHoldS   = (remainS == {NOUT{1'b0}}) ? IDLE : BCAST;
      end
      default: begin
        readyRawS    = 1'b0;
        pendingHoldS = {NOUT{1'b0}};
        stateHoldS   = IDLE;
      end
    endcase
    if (rst) begin
      inReadyS = 1'b0;
      captureS = 1'b0;
    end else begin
      inReadyS = readyRawS;
      captureS = in_valid && readyRawS;
    end
    stateNextS   = captureS ? BCAST : stateHoldS;
    pendingNextS = captureS ? branch_en : pendingHoldS;
  end

  // State, pending branches and the captured token.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR   <= IDLE;
      pendingR <= {NOUT{1'b0}};
      dataR    <= {WIDTH{1'b0}};
    end else begin
      stateR   <= stateNextS;
      pendingR <= pendingNextS;
      if (captureS) begin
        dataR <= in_data;
      end
    end
  end

  assign in_ready  = inReadyS;
  assign busy      = (stateR == BCAST);
  assign out_valid = (stateR == BCAST) ? pendingR : {NOUT{1'b0}};
  assign out_data  = dataR;

`ifdef FORK4_WATCHDOG_EN
  fork4_wdog #(
    .WDOG_CYC (WDOG_CYC)
  ) uWdog (
    .clk       (clk),
    .rst       (rst),
    .bcast     (stateR == BCAST),
    .capture   (captureS),
    .pending   (pendingR),
    .outReady  (out_ready),
    .stallErr  (stall_err),
    .stuckMask (stuck_mask)
  );
`else
  assign stall_err  = 1'b0;
  assign stuck_mask = {NOUT{1'b0}};
`endif

endmodule
